// File: rtl/keypad_emulator.sv
//==============================================================================
// Module   : keypad_emulator
// Purpose  : Emulates key presses on a 4x4 matrix keypad by driving the column
//            lines back to the keypad scanner. Key codes are queued through a
//            valid/ready FIFO. Each key is held for HOLD_TICKS, then all
//            columns are released for GAP_TICKS so the scanner sees a clean
//            release between keys.
// Ports    : clk        - system clock (rising edge)
//            rst        - asynchronous reset, active low
//            kp_row     - row strobe from the scanner (one bit low)
//            kp_col     - column lines to the scanner (low = pressed column)
//            key_valid  - key code offered this cycle
//            key_code   - key to press, 0x0..0xF
//            key_ready  - FIFO not full; push when key_valid && key_ready
//            busy       - pressing, releasing, or keys still queued
//            active_key - code currently (or most recently) pressed
// Options  : KP_EMU_SCAN_HOLD_EN - when defined, HOLD_TICKS counts completed
//            scan passes (PRESS cycles with kp_row == 4'b0111) rather than
//            raw clock cycles.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_emulator #(
  parameter int HOLD_TICKS = 8,
  parameter int GAP_TICKS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic [3:0] active_key
);

  localparam int c_ADDR_W    = $clog2(FIFO_DEPTH);
  localparam int c_MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

  // Counters are loaded with N-1 and the phase ends on the edge after zero
  // is seen, which gives exactly N counted cycles.
  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------------
  // Key-code FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]        r_mem [FIFO_DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same address with differing wrap bits means the writer lapped the reader.
  assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign w_push  = key_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= key_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold / gap counter
  // ---------------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_cnt_zero;
  logic               w_hold_tick;
  logic               w_load_hold;
  logic               w_load_gap;
  logic               w_cnt_dec;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef KP_EMU_SCAN_HOLD_EN
  // One hold tick per completed scan pass: the last row of the pass is strobed.
  assign w_hold_tick = (kp_row == 4'b0111);
`else
  assign w_hold_tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load_hold) begin
      r_cnt <= c_HOLD_LOAD;
    end else if (w_load_gap) begin
      r_cnt <= c_GAP_LOAD;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Active key register
  // ---------------------------------------------------------------------------
  logic [3:0] r_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 4'h0;
    end else if (w_pop) begin
      r_active <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Key map: code -> {row index, column index}; index i means bit i is low.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'h7: pos = {2'd0, 2'd0};
      4'h4: pos = {2'd0, 2'd1};
      4'h1: pos = {2'd0, 2'd2};
      4'h0: pos = {2'd0, 2'd3};
      4'h8: pos = {2'd1, 2'd0};
      4'h5: pos = {2'd1, 2'd1};
      4'h2: pos = {2'd1, 2'd2};
      4'hA: pos = {2'd1, 2'd3};
      4'h9: pos = {2'd2, 2'd0};
      4'h6: pos = {2'd2, 2'd1};
      4'h3: pos = {2'd2, 2'd2};
      4'hB: pos = {2'd2, 2'd3};
      4'hC: pos = {2'd3, 2'd0};
      4'hD: pos = {2'd3, 2'd1};
      4'hE: pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};  // 4'hF
    endcase
    return pos;
  endfunction

  logic [3:0] w_pos;
  logic [3:0] w_row_pat;
  logic [3:0] w_col_pat;

  assign w_pos     = key_pos(r_active);
  assign w_row_pat = ~(4'b0001 << w_pos[3:2]);
  assign w_col_pat = ~(4'b0001 << w_pos[1:0]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_hold = 1'b0;
    w_load_gap  = 1'b0;
    w_cnt_dec   = 1'b0;
    kp_col      = 4'b1111;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_PRESS;
          w_pop       = 1'b1;
          w_load_hold = 1'b1;
        end
      end

      ST_PRESS: begin
        // Combinational path from kp_row: the scanner samples the column
        // on the same edge that advances its row.
        if (kp_row == w_row_pat) begin
          kp_col = w_col_pat;
        end
        if (w_hold_tick) begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_RELEASE;
            w_load_gap  = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (w_cnt_zero) begin
          if (!w_empty) begin
            // Chain straight into the next key without an idle cycle.
            w_state_nxt = ST_PRESS;
            w_pop       = 1'b1;
            w_load_hold = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign key_ready  = !w_full;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign active_key = r_active;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
//==============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Self-checking bench for keypad_emulator. A scanner model cycles
//            kp_row every clock; key codes are offered in directed and random
//            patterns, and every cycle the DUT outputs are compared with a
//            timeline model that schedules each accepted key's press window.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keypad_emulator;

  localparam int H = 8;
  localparam int G = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;
  logic [3:0] active_key;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_TICKS(H),
    .GAP_TICKS (G),
    .FIFO_DEPTH(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kp_row    (kp_row),
    .kp_col    (kp_col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .busy      (busy),
    .active_key(active_key)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of the most recent clock edge since reset release

  // Keypad layout, indexed [row index][column index]; index i = bit i low.
  logic [3:0] kmap [0:3][0:3] = '{
    '{4'h7, 4'h4, 4'h1, 4'h0},
    '{4'h8, 4'h5, 4'h2, 4'hA},
    '{4'h9, 4'h6, 4'h3, 4'hB},
    '{4'hC, 4'hD, 4'hE, 4'hF}
  };

  // Timeline of accepted keys: edge pushed, edge its press starts, press length.
  int         q_push  [$];
  int         q_start [$];
  int         q_len   [$];
  logic [3:0] q_code  [$];

  function automatic logic [3:0] row_of(input int k);
    logic [3:0] one = 4'b0001;
    return ~(one << (k % 4));
  endfunction

  function automatic int press_len(input int s);
`ifdef KP_EMU_SCAN_HOLD_EN
    int seen = 0;
    for (int k = s; k < s + 64 * H; k++) begin
      if (k % 4 == 3) seen++;
      if (seen == H) return k - s + 1;
    end
    return H;
`else
    return H;
`endif
  endfunction

  function automatic int m_count(input int k);
    int c = 0;
    for (int i = 0; i < q_push.size(); i++)
      if (q_push[i] <= k && q_start[i] > k) c++;
    return c;
  endfunction

  function automatic int m_pressing(input int k);
    for (int i = 0; i < q_start.size(); i++)
      if (q_start[i] <= k && k < q_start[i] + q_len[i]) return i;
    return -1;
  endfunction

  function automatic logic m_busy(input int k);
    if (m_count(k) > 0) return 1'b1;
    for (int i = 0; i < q_start.size(); i++)
      if (q_start[i] <= k && k < q_start[i] + q_len[i] + G) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_active(input int k);
    for (int i = q_start.size() - 1; i >= 0; i--)
      if (q_start[i] <= k) return q_code[i];
    return 4'h0;
  endfunction

  function automatic logic [3:0] m_col(input int k);
    int         idx = m_pressing(k);
    int         r   = k % 4;
    logic [3:0] one = 4'b0001;
    if (idx < 0) return 4'b1111;
    for (int ci = 0; ci < 4; ci++)
      if (kmap[r][ci] == q_code[idx]) return ~(one << ci);
    return 4'b1111;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: offer (v, c), check outputs mid-cycle, then advance.
  task automatic step(input logic v, input logic [3:0] c);
    int p;
    int s;
    int last_end;
    key_valid = v;
    key_code  = c;
    @(negedge clk);
    chk("kp_col",     kp_col,            m_col(cyc));
    chk("key_ready",  {3'b0, key_ready}, {3'b0, m_count(cyc) < D});
    chk("busy",       {3'b0, busy},      {3'b0, m_busy(cyc)});
    chk("active_key", active_key,        m_active(cyc));
    if (v && m_count(cyc) < D) begin
      p        = cyc + 1;
      last_end = (q_start.size() > 0) ?
                 q_start[q_start.size()-1] + q_len[q_len.size()-1] + G : 0;
      s        = (p + 1 > last_end) ? p + 1 : last_end;
      q_push.push_back(p);
      q_start.push_back(s);
      q_len.push_back(press_len(s));
      q_code.push_back(c);
    end
    @(posedge clk);
    cyc++;
    #1;
    kp_row = row_of(cyc);
  endtask

  task automatic model_clear();
    q_push.delete();
    q_start.delete();
    q_len.delete();
    q_code.delete();
  endtask

  initial begin
    bit found;

    // Reset with the scanner running and a key offered: nothing may happen.
    rst       = 1'b0;
    kp_row    = 4'b1110;
    key_valid = 1'b1;
    key_code  = 4'h5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      kp_row = row_of(i);
      #1;
      chk("rst_kp_col",     kp_col,            4'b1111);
      chk("rst_key_ready",  {3'b0, key_ready}, 4'h1);
      chk("rst_busy",       {3'b0, busy},      4'h0);
      chk("rst_active_key", active_key,        4'h0);
    end
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b0;
    cyc       = 0;
    model_clear();
    @(posedge clk);
    #1;
    kp_row = row_of(cyc);

    // Single key 0xA into an idle block, run until fully idle again.
    step(1'b1, 4'hA);
    for (int i = 0; i < H + G + 4; i++) step(1'b0, 4'h0);

    // Four codes on consecutive edges, all accepted and pressed in order.
    step(1'b1, 4'h0);
    step(1'b1, 4'hC);
    step(1'b1, 4'h9);
    step(1'b1, 4'h7);
    for (int i = 0; i < 4 * (H + G) + 4; i++) step(1'b0, 4'h0);

    // Fill the FIFO while a key is held; the fifth offer must be refused.
    step(1'b1, 4'h5);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    step(1'b1, 4'h6);
    for (int i = 0; i < 5 * (H + G) + 4; i++) step(1'b0, 4'h0);

    // Randomized offers, then drain.
    for (int i = 0; i < 250; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < (D + 1) * (H + G) + 4; i++) step(1'b0, 4'h0);

    // Reset asserted mid-press of 0x8 with two codes queued.
    step(1'b1, 4'h8);
    step(1'b1, 4'h2);
    step(1'b1, 4'hE);
    found = 1'b0;
    for (int i = 0; i < 2 * H && !found; i++) begin
      if (m_pressing(cyc) >= 0 && m_col(cyc) != 4'b1111) found = 1'b1;
      else step(1'b0, 4'h0);
    end
    checks++;
    if (!found) begin
      failures++;
      $error("FAIL reset_setup cyc=%0d observed=no_press expected=press_of_8", cyc);
    end
    #1;
    chk("pre_rst_kp_col", kp_col, m_col(cyc));
    rst = 1'b0;
    #1;
    chk("async_rst_kp_col",     kp_col,            4'b1111);
    chk("async_rst_busy",       {3'b0, busy},      4'h0);
    chk("async_rst_key_ready",  {3'b0, key_ready}, 4'h1);
    chk("async_rst_active_key", active_key,        4'h0);
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    kp_row = row_of(cyc);
    for (int i = 0; i < 3 * (H + G); i++) step(1'b0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
